// File: rtl/bus_arbiter4_pkg.sv
// bus_arbiter4_pkg -- shared types, sizes and helpers for the 4-master bus arbiter.
//   state_t        : arbiter FSM state {IDLE, OWN}
//   NUM_MASTERS    : number of requesting masters (4)
//   SEL_W          : width of the binary owner index (2)
//   idx_to_onehot  : binary owner index -> one-hot grant vector
package bus_arbiter4_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int NUM_MASTERS = 4;
    localparam int SEL_W       = 2;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_MASTERS-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// rr_pick4 -- combinational round-robin winner search over four requesters.
// The search starts at (ptr+1) mod 4 and wraps, so the master at ptr is
// considered last.
//   req [3:0] : request vector, bit i = master i
//   ptr [1:0] : most recent owner
//   any       : at least one request is set
//   idx [1:0] : winning master index (0 when any=0)
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_W-1:0]       ptr,
    output logic                   any,
    output logic [SEL_W-1:0]       idx
);

    logic [NUM_MASTERS-1:0] rot_s;
    logic [SEL_W-1:0]       pos_s;
    logic [SEL_W-1:0]       off_s;

    // Rotate requests so that bit 0 is the first candidate after ptr, then priority-encode.
    always_comb begin
        rot_s = 4'b0000;
        pos_s = 2'd0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            pos_s    = ptr + 2'd1 + j[1:0];
            rot_s[j] = req[pos_s];
        end
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        any = |req;
        if (any) begin
            idx = ptr + 2'd1 + off_s;
        end else begin
            idx = 2'd0;
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4 -- 4-master round-robin bus arbiter with registered grant.
// Optional hold-timeout logic is compiled only when BUS_ARBITER4_TIMEOUT_EN is
// defined; otherwise there is no hold counter and TIMEOUT is tied low.
//   MAX_HOLD     : max consecutive owned cycles before a forced release (2..255)
//   CLK          : clock, rising edge
//   RST          : asynchronous active-high reset
//   REQ [3:0]    : per-master requests
//   LAST         : owner's final transfer cycle (ignored in IDLE)
//   GNT [3:0]    : registered one-hot grant or zero
//   SEL [1:0]    : registered owner index, held at last owner while idle
//   BUSY         : high while a grant is active
//   TIMEOUT      : one-cycle pulse following a forced release
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] REQ,
    input  logic                   LAST,
    output logic [NUM_MASTERS-1:0] GNT,
    output logic [SEL_W-1:0]       SEL,
    output logic                   BUSY,
    output logic                   TIMEOUT
);

    state_t                 state_r;
    logic [NUM_MASTERS-1:0] gnt_r;
    logic [SEL_W-1:0]       sel_r;
    logic [SEL_W-1:0]       ptr_r;
    logic                   busy_r;

    logic                   pick_any_s;
    logic [SEL_W-1:0]       pick_idx_s;
    logic                   release_s;
    logic                   forced_s;

`ifdef BUS_ARBITER4_TIMEOUT_EN
    // hold_cnt_r counts completed owned cycles; the owner's MAX_HOLD-th cycle
    // is the one during which the count equals MAX_HOLD-1.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    logic [7:0]             hold_cnt_r;
    logic                   timeout_r;
    logic                   others_s;
`endif

    // While owning, ptr_r equals the owner, so one search serves both states.
    rr_pick4 u_pick (
        .req (REQ),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Release decision: normal release wins over a coincident forced release.
    always_comb begin
        release_s = 1'b0;
        forced_s  = 1'b0;
        if (state_r == OWN) begin
            release_s = LAST | ~REQ[sel_r];
        end else begin
            release_s = 1'b0;
        end
`ifdef BUS_ARBITER4_TIMEOUT_EN
        others_s = |(REQ & ~gnt_r);
        if ((state_r == OWN) && (hold_cnt_r >= HOLD_LIMIT) && others_s && !release_s) begin
            forced_s = 1'b1;
        end else begin
            forced_s = 1'b0;
        end
`endif
    end

    // Arbiter FSM with registered grant, select, busy and timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            ptr_r   <= 2'd3;
            busy_r  <= 1'b0;
`ifdef BUS_ARBITER4_TIMEOUT_EN
            hold_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
`ifdef BUS_ARBITER4_TIMEOUT_EN
                    timeout_r  <= 1'b0;
                    hold_cnt_r <= 8'd0;
`endif
                    if (pick_any_s) begin
                        state_r <= OWN;
                        gnt_r   <= idx_to_onehot(pick_idx_s);
                        sel_r   <= pick_idx_s;
                        ptr_r   <= pick_idx_s;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                    end
                end
                OWN: begin
                    if (release_s || forced_s) begin
`ifdef BUS_ARBITER4_TIMEOUT_EN
                        timeout_r  <= forced_s;
                        hold_cnt_r <= 8'd0;
`endif
                        if (pick_any_s) begin
                            gnt_r   <= idx_to_onehot(pick_idx_s);
                            sel_r   <= pick_idx_s;
                            ptr_r   <= pick_idx_s;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= 4'b0000;
                            busy_r  <= 1'b0;
                        end
                    end else begin
`ifdef BUS_ARBITER4_TIMEOUT_EN
                        timeout_r <= 1'b0;
                        if (hold_cnt_r < HOLD_LIMIT) begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT  = gnt_r;
    assign SEL  = sel_r;
    assign BUSY = busy_r;
`ifdef BUS_ARBITER4_TIMEOUT_EN
    assign TIMEOUT = timeout_r;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4 -- table-driven self-checking bench for bus_arbiter4.
// Inputs are driven after the falling edge; outputs are sampled on the next
// falling edge, i.e. after the rising edge that consumed the inputs.
module tb_bus_arbiter4;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       LAST;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       BUSY;
    logic       TIMEOUT;

    int checks   = 0;
    int failures = 0;

    bus_arbiter4 #(.MAX_HOLD(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .LAST    (LAST),
        .GNT     (GNT),
        .SEL     (SEL),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] req;
        logic       last;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [23];

    task automatic check_out(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic eb, input logic et);
        checks++;
        if (GNT !== eg) begin
            failures++;
            $display("FAIL %s GNT got=%b want=%b", name, GNT, eg);
        end
        checks++;
        if (SEL !== es) begin
            failures++;
            $display("FAIL %s SEL got=%0d want=%0d", name, SEL, es);
        end
        checks++;
        if (BUSY !== eb) begin
            failures++;
            $display("FAIL %s BUSY got=%b want=%b", name, BUSY, eb);
        end
        checks++;
        if (TIMEOUT !== et) begin
            failures++;
            $display("FAIL %s TIMEOUT got=%b want=%b", name, TIMEOUT, et);
        end
    endtask

    // Apply inputs for one rising edge, then check the registered result.
    task automatic step(input string name, input logic [3:0] r, input logic l,
                        input logic [3:0] eg, input logic [1:0] es, input logic eb, input logic et);
        REQ  = r;
        LAST = l;
        @(posedge CLK);
        @(negedge CLK);
        check_out(name, eg, es, eb, et);
    endtask

    initial begin
        //            req      last  gnt      sel   busy  to
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // first grant: master 0
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}; // rotation, no gap
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0}; // wrap to 0
        tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // hold
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // owner drops, none left
        tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // single requester
        tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // held past 4 cycles, alone
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0}; // LAST -> idle, SEL holds 2
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[14] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // ptr=2: search 3,0,1
        tbl[15] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // non-owner ignored
        tbl[16] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0}; // owner 1 drops -> 3
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0}; // LAST ignored in idle
        tbl[19] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // ptr=3: 1 before 2
        tbl[20] = '{4'b0110, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[21] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}; // ptr=2: 3,0 idle -> 1
        tbl[22] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}; // sole requester re-granted

        RST  = 1'b0;
        REQ  = 4'b0000;
        LAST = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        check_out("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].last,
                 tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].to);
        end

        // Mid-ownership reset: grant drops without a clock edge.
        RST = 1'b1;
        #1;
        check_out("midrst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        REQ  = 4'b0011;
        LAST = 1'b0;
        @(negedge CLK);
        check_out("midrst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        RST = 1'b0;
        step("midrst_first", 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);

        // Master 0 never asserts LAST while master 2 waits.
        step("hold1", 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("hold2", 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("hold3", 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef BUS_ARBITER4_TIMEOUT_EN
        step("timeout_fire", 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
        step("timeout_once", 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        step("no_timeout_a", 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("no_timeout_b", 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("to_master2", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
`endif
        // Master 2 alone: held well past MAX_HOLD with no TIMEOUT.
        for (int k = 0; k < 6; k++) begin
            step($sformatf("alone%0d", k), 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        // LAST coincides with an expired hold: normal handover, no TIMEOUT.
        step("coincide", 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("after_coin", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive owned cycles before a forced release; legal range 2..255.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port REQ, input, 4: per-master bus request; bit i belongs to master i.
REQ-005 SHALL have port LAST, input, 1: the current owner's final transfer cycle; ignored when no grant is active.
REQ-006 SHALL have port GNT, output, 4: registered one-hot grant, or all zero.
REQ-007 SHALL have port SEL, output, 2: registered binary index of the owner; drives the downstream 4:1 bus multiplexer select.
REQ-008 SHALL have port BUSY, output, 1: high while a grant is active.
REQ-009 SHALL have port TIMEOUT, output, 1: one-cycle pulse on a forced release.

Function
REQ-010 SHALL implement two states:
- IDLE: no grant.
- OWN: exactly one GNT bit is high.
REQ-011 SHALL, in IDLE with REQ != 0 at edge n, assert GNT for the winner from edge n+1 and enter OWN; grant latency is exactly one cycle.
REQ-012 SHALL pick the winner round-robin: search from index (PTR+1) mod 4 upward with wrap, where PTR is the most recent owner; the most recent owner is eligible last.
REQ-013 SHALL, in OWN, release the grant on either event:
- LAST=1;
- REQ[owner]=0.
REQ-014 SHALL, on release at edge n, grant the next requester by REQ-012 at edge n+1, with no dead cycle; if no REQ bit is set, it SHALL enter IDLE with GNT=0.
REQ-015 SHALL ignore changes on non-owner REQ bits during OWN, except when evaluating the next winner.
REQ-016 SHALL load PTR with the owner index on every grant.
REQ-017 SHALL hold SEL at the last owner's index while in IDLE; SEL SHALL change only when a new grant is issued.
REQ-018 SHALL set BUSY=1 exactly when GNT != 0.
REQ-019 SHALL keep GNT one-hot or zero in every cycle, and SEL SHALL equal the encoding of GNT whenever GNT != 0.

Reset
REQ-020 SHALL, while RST=1, force these values, independent of CLK:
- GNT=0, SEL=0, BUSY=0, TIMEOUT=0;
- state=IDLE, hold counter=0, PTR=3, so that master 0 wins first.
REQ-021 SHALL drop any active grant immediately when RST is asserted mid-ownership; the first grant after RST deassertion follows REQ-011.

Configuration
REQ-022 SHALL compile the hold-timeout logic only when macro BUS_ARBITER4_TIMEOUT_EN is defined.
REQ-023 SHALL, with BUS_ARBITER4_TIMEOUT_EN defined:
- count owned cycles, with the counter cleared on each new grant;
- when the count reaches MAX_HOLD and another REQ bit is set, force a release, pulse TIMEOUT for one cycle, and hand over per REQ-014;
- with no other requester, hold the grant and saturate the counter.
REQ-024 SHALL NOT pulse TIMEOUT when a normal release (REQ-013) and the timeout coincide; the release is treated as normal.
REQ-025 SHALL, without BUS_ARBITER4_TIMEOUT_EN, contain no counter, tie TIMEOUT to 0, and release only per REQ-013.

Structure
REQ-026 SHALL place the following in shared package bus_arbiter4_pkg:
- state enum {IDLE, OWN};
- constants NUM_MASTERS=4 and SEL_W=2.
REQ-027 SHALL implement the round-robin search as one combinational sub-module, rr_pick4, with inputs req[3:0] and ptr[1:0] and outputs any and idx[1:0].

Verification
REQ-028 SHALL cover reset priority:
- stimulus: REQ=4'b1111 after reset, LAST pulsed each ownership;
- response: SEL sequence 0,1,2,3,0, with one grant per release and no idle gaps.
REQ-029 SHALL cover a single requester:
- stimulus: REQ=4'b0100 for 5 cycles, then LAST;
- response: GNT=4'b0100 from cycle 1, SEL=2, BUSY=1; the cycle after LAST, GNT=0, BUSY=0, SEL stays 2.
REQ-030 SHALL cover owner drop:
- stimulus: owner 1 deasserts REQ[1] while REQ[3]=1;
- response: next cycle GNT=4'b1000, SEL=3.
REQ-031 SHALL cover timeout with BUS_ARBITER4_TIMEOUT_EN and MAX_HOLD=4:
- stimulus: master 0 holds REQ and never asserts LAST, REQ[2]=1;
- response: TIMEOUT pulses once, then GNT=4'b0100.
- with REQ[2]=0: no TIMEOUT, grant held.
REQ-032 SHALL cover coincident events:
- stimulus: LAST coincides with the timeout edge;
- response: TIMEOUT=0 and normal handover.
REQ-033 SHALL cover mid-grant reset:
- stimulus: assert RST during OWN;
- response: GNT=0, SEL=0 without a clock edge; after release with REQ=4'b0011, master 0 wins first.
